// File: rtl/hazard_scoreboard.sv
// Producer-side hazard tracker: shadows in-flight writes in EX/MEM/WB
// and stalls ID on load-use and jr-on-load hazards.
module hazard_scoreboard #(
    parameter int         CNT_W = 32,
    parameter logic [2:0] PC_JR = 3'b011
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ID_Valid,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [4:0]       ID_RegDst,
    input  logic             ID_RegWr,
    input  logic             ID_MemRead,
    input  logic [2:0]       ID_PCSrc,
    input  logic             EX_Flush,
    input  logic             Ext_Stall,
    output logic             Stall_PC,
    output logic             Stall_IF_ID,
    output logic             Bubble_ID_EX,
    output logic [31:0]      Pending,
    output logic [CNT_W-1:0] Stall_Count
);

    typedef struct packed {
        logic       v;
        logic       wr;
        logic       ld;
        logic [4:0] dst;
    } slot_t;

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d, mem_d, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_ld, mem_ld, rs_ex, rt_ex, rs_mem;
    logic lu, jr, haz;

    function automatic logic live(input slot_t s);
        return s.v && s.wr && (s.dst != 5'd0);
    endfunction

    function automatic logic [31:0] onehot(input slot_t s);
        logic [31:0] m;
        m = '0;
        if (live(s)) m[s.dst] = 1'b1;
        return m;
    endfunction

    always_comb begin
        ex_ld  = live(ex_q) && ex_q.ld;
        mem_ld = live(mem_q) && mem_q.ld;
        rs_ex  = ID_Rs == ex_q.dst;
        rt_ex  = ID_Rt == ex_q.dst;
        rs_mem = ID_Rs == mem_q.dst;
        lu = ID_Valid && ex_ld
           && ((ID_UsesRs && rs_ex) || (ID_UsesRt && rt_ex));
        jr = ID_Valid && (ID_PCSrc == PC_JR)
           && ((ex_ld && rs_ex) || (mem_ld && rs_mem));
        // ID is ignored while reset is high, so no hazard can be raised then
        haz = (lu || jr) && !EX_Flush && !reset;
    end

    assign Stall_PC     = haz || Ext_Stall;
    assign Stall_IF_ID  = haz || Ext_Stall;
    assign Bubble_ID_EX = (haz || EX_Flush) && !Ext_Stall;
    assign Pending      = onehot(ex_q) | onehot(mem_q) | onehot(wb_q);
    assign Stall_Count  = cnt_q;

    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        cnt_d = cnt_q;
        if (!Ext_Stall) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            if (haz || EX_Flush || !ID_Valid) begin
                ex_d = '0;
            end else begin
                ex_d = '{v: 1'b1, wr: ID_RegWr,
                         ld: ID_MemRead, dst: ID_RegDst};
            end
            if (haz && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule
